// File: rtl/alu_bist_pkg.sv
// Shared ALU BIST definitions: op codes, test-vector layout and small helpers.
package alu_bist_pkg;

  localparam int unsigned VecW   = 64;
  localparam int unsigned OpW    = 5;
  localparam int unsigned NumOps = 18;
  localparam int unsigned CntW   = 8;

  // Vector field positions, MSB first.
  localparam int unsigned OpMsb = 63;
  localparam int unsigned OpLsb = 59;
  localparam int unsigned XMsb  = 58;
  localparam int unsigned XLsb  = 43;
  localparam int unsigned YMsb  = 42;
  localparam int unsigned YLsb  = 27;
  localparam int unsigned FMsb  = 26;
  localparam int unsigned FLsb  = 23;
  localparam int unsigned OMsb  = 22;
  localparam int unsigned OLsb  = 7;
  localparam int unsigned FlMsb = 6;
  localparam int unsigned FlLsb = 3;

  typedef enum logic [OpW-1:0] {
    OpOr    = 5'd0,
    OpAnd   = 5'd1,
    OpXor   = 5'd2,
    OpCpl   = 5'd3,
    OpAdd   = 5'd4,
    OpAdc   = 5'd5,
    OpSub   = 5'd6,
    OpSbc   = 5'd7,
    OpRlc   = 5'd8,
    OpRl    = 5'd9,
    OpRrc   = 5'd10,
    OpRr    = 5'd11,
    OpSla   = 5'd12,
    OpSra   = 5'd13,
    OpSrl   = 5'd14,
    OpSwap  = 5'd15,
    OpDaa   = 5'd16,
    OpAdd16 = 5'd17
  } aluOpE;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StSettle,
    StCheck,
    StDone
  } bistStateE;

  function automatic logic isValidOp(input logic [OpW-1:0] op);
    return op < OpW'(NumOps);
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CntW-1:0] satInc(input logic [CntW-1:0] v);
    return (v == {CntW{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_bist_if.sv
// BIST control, ROM and ALU signal bundle; master is the BIST engine side.
interface alu_bist_if
  import alu_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W-1:0] vec_addr;
  logic              vec_rd;
  logic [VecW-1:0]   vec_data;
  logic [OpW-1:0]    alu_op;
  logic [15:0]       alu_x;
  logic [15:0]       alu_y;
  logic [3:0]        alu_f;
  logic [15:0]       alu_o;
  logic [3:0]        alu_fres;
  logic [OpW-1:0]    sel_op;
  logic [CntW-1:0]   sel_err;
  logic [CntW-1:0]   sel_total;
  logic [CntW-1:0]   err_total;
  logic [ADDR_W-1:0] first_fail;
  logic              first_fail_vld;

  modport master (
    input  start, vec_data, alu_o, alu_fres, sel_op,
    output busy, done, pass, vec_addr, vec_rd, alu_op, alu_x, alu_y, alu_f,
           sel_err, sel_total, err_total, first_fail, first_fail_vld
  );

  modport slave (
    output start, vec_data, alu_o, alu_fres, sel_op,
    input  busy, done, pass, vec_addr, vec_rd, alu_op, alu_x, alu_y, alu_f,
           sel_err, sel_total, err_total, first_fail, first_fail_vld
  );
endinterface

// File: rtl/alu_bist_counters.sv
// Per-op error/total counters with saturation, clear and readout mux.
module alu_bist_counters
  import alu_bist_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic            mismatch_i,
  input  logic [OpW-1:0]  op_i,
  input  logic [OpW-1:0]  sel_i,
  output logic [CntW-1:0] selErr_o,
  output logic [CntW-1:0] selTotal_o,
  output logic [CntW-1:0] errTotal_o,
  output logic            satHit_o,
  output logic            sat_o
);
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  logic [CntW-1:0] errQ   [NumOps];
  logic [CntW-1:0] totalQ [NumOps];
  logic [CntW-1:0] errTotalQ;
  logic            satQ;
  logic            opValid;
  logic            selValid;
  logic            countErr;
  logic [OpW-1:0]  opIdx;
  logic [OpW-1:0]  selIdx;

  // Decode the op under check and flag any increment that would overflow.
  always_comb begin
    opValid  = isValidOp(op_i);
    opIdx    = opValid ? op_i : '0;
    // Invalid ops always count as errors, whatever the ALU returned.
    countErr = mismatch_i || !opValid;
    satHit_o = 1'b0;
    if (inc_i) begin
      if (opValid && (totalQ[opIdx] == CntMax)) satHit_o = 1'b1;
      if (opValid && mismatch_i && (errQ[opIdx] == CntMax)) satHit_o = 1'b1;
      if (countErr && (errTotalQ == CntMax)) satHit_o = 1'b1;
    end
  end

  // Counter state: cleared on reset or clear, bumped once per checked vector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumOps; i++) begin
        errQ[i]   <= '0;
        totalQ[i] <= '0;
      end
      errTotalQ <= '0;
      satQ      <= 1'b0;
    end else if (clr_i) begin
      for (int i = 0; i < NumOps; i++) begin
        errQ[i]   <= '0;
        totalQ[i] <= '0;
      end
      errTotalQ <= '0;
      satQ      <= 1'b0;
    end else if (inc_i) begin
      if (opValid) begin
        totalQ[opIdx] <= satInc(totalQ[opIdx]);
        if (mismatch_i) errQ[opIdx] <= satInc(errQ[opIdx]);
      end
      if (countErr) errTotalQ <= satInc(errTotalQ);
      if (satHit_o) satQ <= 1'b1;
    end
  end

  // Readout mux; out-of-range selects read zero.
  always_comb begin
    selValid   = isValidOp(sel_i);
    selIdx     = selValid ? sel_i : '0;
    selErr_o   = selValid ? errQ[selIdx] : '0;
    selTotal_o = selValid ? totalQ[selIdx] : '0;
  end

  assign errTotal_o = errTotalQ;
  assign sat_o      = satQ;

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test engine: fetches vectors, drives the ALU, compares, counts.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int unsigned NUM_TESTS = 27,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned SETTLE    = 1
) (
  input logic        clk_i,
  input logic        rst_ni,
  alu_bist_if.master bus
);
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SetW-1:0]   SettleLast = SetW'(SETTLE - 1);
  localparam logic [ADDR_W-1:0] LastIdx    = ADDR_W'((NUM_TESTS == 0) ? 0 : NUM_TESTS - 1);

  bistStateE         stateQ;
  logic [ADDR_W-1:0] idxQ;
  logic [SetW-1:0]   settleQ;
  logic              busyQ;
  logic              doneQ;
  logic              passQ;
  logic              vecRdQ;
  logic [OpW-1:0]    aluOpQ;
  logic [15:0]       aluXQ;
  logic [15:0]       aluYQ;
  logic [3:0]        aluFQ;
  logic [15:0]       expOQ;
  logic [3:0]        expFlQ;
  logic [ADDR_W-1:0] firstFailQ;
  logic              firstFailVldQ;

  logic            mismatch;
  logic            failNow;
  logic            checkEn;
  logic            clrCnt;
  logic [CntW-1:0] errTotal;
  logic            satHit;
  logic            sat;
  logic            unusedPad;

  assign unusedPad = ^bus.vec_data[2:0];

  // Compare and control strobes for the counter bank.
  always_comb begin
    mismatch = (bus.alu_o != expOQ) || (bus.alu_fres != expFlQ);
    failNow  = mismatch || !isValidOp(aluOpQ);
    checkEn  = (stateQ == StCheck);
    clrCnt   = bus.start && ((stateQ == StIdle) || (stateQ == StDone));
  end

  alu_bist_counters u_counters (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clrCnt),
    .inc_i      (checkEn),
    .mismatch_i (mismatch),
    .op_i       (aluOpQ),
    .sel_i      (bus.sel_op),
    .selErr_o   (bus.sel_err),
    .selTotal_o (bus.sel_total),
    .errTotal_o (errTotal),
    .satHit_o   (satHit),
    .sat_o      (sat)
  );

  // Run sequencer with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stateQ        <= StIdle;
      idxQ          <= '0;
      settleQ       <= '0;
      busyQ         <= 1'b0;
      doneQ         <= 1'b0;
      passQ         <= 1'b0;
      vecRdQ        <= 1'b0;
      aluOpQ        <= '0;
      aluXQ         <= '0;
      aluYQ         <= '0;
      aluFQ         <= '0;
      expOQ         <= '0;
      expFlQ        <= '0;
      firstFailQ    <= '0;
      firstFailVldQ <= 1'b0;
    end else begin
      case (stateQ)
        StIdle, StDone: begin
          if (bus.start) begin
            idxQ          <= '0;
            firstFailQ    <= '0;
            firstFailVldQ <= 1'b0;
            if (NUM_TESTS == 0) begin
              // Nothing to run: report an immediate clean pass.
              stateQ <= StDone;
              doneQ  <= 1'b1;
              passQ  <= 1'b1;
            end else begin
              stateQ <= StFetch;
              busyQ  <= 1'b1;
              doneQ  <= 1'b0;
              passQ  <= 1'b0;
              vecRdQ <= 1'b1;
            end
          end
        end
        StFetch: begin
          vecRdQ <= 1'b0;
          stateQ <= StLoad;
        end
        StLoad: begin
          aluOpQ  <= bus.vec_data[OpMsb:OpLsb];
          aluXQ   <= bus.vec_data[XMsb:XLsb];
          aluYQ   <= bus.vec_data[YMsb:YLsb];
          aluFQ   <= bus.vec_data[FMsb:FLsb];
          expOQ   <= bus.vec_data[OMsb:OLsb];
          expFlQ  <= bus.vec_data[FlMsb:FlLsb];
          settleQ <= SettleLast;
          stateQ  <= StSettle;
        end
        StSettle: begin
          if (settleQ == '0) stateQ <= StCheck;
          else settleQ <= settleQ - 1'b1;
        end
        StCheck: begin
          if (failNow && !firstFailVldQ) begin
            firstFailQ    <= idxQ;
            firstFailVldQ <= 1'b1;
          end
          if (idxQ == LastIdx) begin
            stateQ <= StDone;
            busyQ  <= 1'b0;
            doneQ  <= 1'b1;
            // Fold in this vector's outcome; the counters only update at this edge.
            passQ  <= !(failNow || (errTotal != '0) || sat || satHit);
          end else begin
            idxQ   <= idxQ + 1'b1;
            stateQ <= StFetch;
            vecRdQ <= 1'b1;
          end
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  assign bus.busy           = busyQ;
  assign bus.done           = doneQ;
  assign bus.pass           = passQ;
  assign bus.vec_addr       = idxQ;
  assign bus.vec_rd         = vecRdQ;
  assign bus.alu_op         = aluOpQ;
  assign bus.alu_x          = aluXQ;
  assign bus.alu_y          = aluYQ;
  assign bus.alu_f          = aluFQ;
  assign bus.err_total      = errTotal;
  assign bus.first_fail     = firstFailQ;
  assign bus.first_fail_vld = firstFailVldQ;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: small 3-vector instance plus a 300-vector saturation instance.
module tb_alu_bist;
  import alu_bist_pkg::*;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_bist_if #(.ADDR_W(8)) busA ();
  alu_bist_if #(.ADDR_W(9)) busS ();

  alu_bist #(.NUM_TESTS(3), .ADDR_W(8), .SETTLE(1)) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (busA)
  );

  alu_bist #(.NUM_TESTS(300), .ADDR_W(9), .SETTLE(2)) dutSat (
    .clk_i  (clk),
    .rst_ni (rstN),
    .bus    (busS)
  );

  logic [63:0] romA [256];
  logic [63:0] satVec;
  logic [4:0]  maskOp;
  logic [15:0] oMask;
  logic [3:0]  fMask;

  function automatic logic [63:0] mkVec(input logic [4:0] op, input logic [15:0] x,
                                        input logic [15:0] y, input logic [3:0] f,
                                        input logic [15:0] o, input logic [3:0] fl);
    return {op, x, y, f, o, fl, 3'b000};
  endfunction

  // Tiny reference ALU covering the ops the vectors use.
  function automatic logic [15:0] refAlu(input logic [4:0] op, input logic [15:0] x,
                                         input logic [15:0] y);
    logic [15:0] r;
    r = '0;
    if (op == OpOr) r = x | y;
    else if (op == OpAdd) r = x + y;
    else if (op == OpSwap) r = {x[15:8], x[3:0], x[7:4]};
    return r;
  endfunction

  // Synchronous ROMs: data valid the cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (busA.vec_rd) busA.vec_data <= romA[busA.vec_addr];
    if (busS.vec_rd) busS.vec_data <= satVec;
  end

  // ALU stubs; the small one can corrupt results for one chosen op.
  always_comb begin
    busA.alu_o    = refAlu(busA.alu_op, busA.alu_x, busA.alu_y);
    busA.alu_fres = 4'h0;
    if (busA.alu_op == maskOp) begin
      busA.alu_o    = busA.alu_o ^ oMask;
      busA.alu_fres = fMask;
    end
    busS.alu_o    = refAlu(busS.alu_op, busS.alu_x, busS.alu_y);
    busS.alu_fres = 4'h0;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulseStartA();
    @(posedge clk);
    #1 busA.start = 1'b1;
    @(posedge clk);
    #1 busA.start = 1'b0;
  endtask

  // Counts cycles from the start-sampling edge until done; optional stray start pulse.
  task automatic waitDoneA(input int maxCyc, input int pokeAt, output int cyc,
                           output logic busy1, output logic rd1, output logic done1);
    cyc = 0;
    busy1 = 1'b0;
    rd1 = 1'b0;
    done1 = 1'b0;
    for (int i = 1; i <= maxCyc; i++) begin
      @(negedge clk);
      if (i == 1) begin
        busy1 = busA.busy;
        rd1   = busA.vec_rd;
        done1 = busA.done;
      end
      if (busA.done) begin
        cyc = i;
        break;
      end
      busA.start = (i == pokeAt);
    end
    busA.start = 1'b0;
  endtask

  task automatic readSelA(input logic [4:0] op, output logic [7:0] e, output logic [7:0] t);
    busA.sel_op = op;
    #1;
    e = busA.sel_err;
    t = busA.sel_total;
  endtask

  int          cyc;
  logic        b1, r1, d1;
  logic [7:0]  e, t;

  initial begin
    rstN = 1'b0;
    busA.start = 1'b0;
    busA.sel_op = '0;
    busS.start = 1'b0;
    busS.sel_op = '0;
    maskOp = 5'd31;
    oMask = '0;
    fMask = '0;
    for (int i = 0; i < 256; i++) romA[i] = '0;
    romA[0] = mkVec(OpAdd, 16'h0012, 16'h0034, 4'h0, 16'h0046, 4'h0);
    romA[1] = mkVec(OpOr, 16'h0F00, 16'h00F0, 4'h0, 16'h0FF0, 4'h0);
    romA[2] = mkVec(OpSwap, 16'h00F0, 16'h0000, 4'h5, 16'h000F, 4'h0);
    satVec  = mkVec(OpOr, 16'h0001, 16'h0002, 4'h0, 16'h0000, 4'h0);

    // Reset state
    #12;
    checkVal("rst_busy", busA.busy, 1'b0);
    checkVal("rst_done", busA.done, 1'b0);
    checkVal("rst_pass", busA.pass, 1'b0);
    checkVal("rst_vec_rd", busA.vec_rd, 1'b0);
    checkVal("rst_alu_x", busA.alu_x, 16'h0);
    checkVal("rst_err_total", busA.err_total, 8'h0);
    @(negedge clk);
    rstN = 1'b1;

    // Run A: all vectors match; a stray start mid-run is ignored
    pulseStartA();
    waitDoneA(60, 6, cyc, b1, r1, d1);
    checkVal("A_latency", cyc, 13);
    checkVal("A_busy_c1", b1, 1'b1);
    checkVal("A_rd_c1", r1, 1'b1);
    checkVal("A_busy_at_done", busA.busy, 1'b0);
    checkVal("A_pass", busA.pass, 1'b1);
    checkVal("A_err_total", busA.err_total, 8'h0);
    checkVal("A_ff_vld", busA.first_fail_vld, 1'b0);
    checkVal("A_alu_op_hold", busA.alu_op, 5'd15);
    checkVal("A_alu_x_hold", busA.alu_x, 16'h00F0);
    checkVal("A_alu_f_hold", busA.alu_f, 4'h5);
    readSelA(5'd4, e, t);
    checkVal("A_add_total", t, 8'd1);
    checkVal("A_add_err", e, 8'd0);
    readSelA(5'd0, e, t);
    checkVal("A_or_total", t, 8'd1);
    readSelA(5'd20, e, t);
    checkVal("A_sel20_total", t, 8'd0);
    repeat (3) @(negedge clk);
    checkVal("A_done_held", busA.done, 1'b1);

    // Run B: ADD returns wrong flags
    maskOp = OpAdd;
    fMask = 4'h1;
    pulseStartA();
    waitDoneA(60, 0, cyc, b1, r1, d1);
    checkVal("B_done_cleared", d1, 1'b0);
    checkVal("B_latency", cyc, 13);
    checkVal("B_pass", busA.pass, 1'b0);
    checkVal("B_err_total", busA.err_total, 8'd1);
    checkVal("B_first_fail", busA.first_fail, 8'd0);
    checkVal("B_ff_vld", busA.first_fail_vld, 1'b1);
    readSelA(5'd4, e, t);
    checkVal("B_add_err", e, 8'd1);
    checkVal("B_add_total", t, 8'd1);

    // Run C: only the SWAP vector mismatches
    maskOp = OpSwap;
    oMask = 16'h00FF;
    fMask = 4'h0;
    pulseStartA();
    waitDoneA(60, 0, cyc, b1, r1, d1);
    checkVal("C_first_fail", busA.first_fail, 8'd2);
    checkVal("C_ff_vld", busA.first_fail_vld, 1'b1);
    checkVal("C_err_total", busA.err_total, 8'd1);
    checkVal("C_pass", busA.pass, 1'b0);
    readSelA(5'd15, e, t);
    checkVal("C_swap_err", e, 8'd1);
    readSelA(5'd4, e, t);
    checkVal("C_add_err_cleared", e, 8'd0);

    // Run D: vector 1 carries invalid op 20
    maskOp = 5'd31;
    oMask = '0;
    romA[1] = mkVec(5'd20, 16'h0F00, 16'h00F0, 4'h0, 16'h0FF0, 4'h0);
    pulseStartA();
    waitDoneA(60, 0, cyc, b1, r1, d1);
    checkVal("D_err_total", busA.err_total, 8'd1);
    checkVal("D_pass", busA.pass, 1'b0);
    readSelA(5'd0, e, t);
    checkVal("D_or_total", t, 8'd0);
    readSelA(5'd20, e, t);
    checkVal("D_sel20_err", e, 8'd0);
    readSelA(5'd4, e, t);
    checkVal("D_add_total", t, 8'd1);
    checkVal("D_add_err", e, 8'd0);
    readSelA(5'd15, e, t);
    checkVal("D_swap_err", e, 8'd0);

    // Run E: reset during SETTLE of vector 1, then a fresh run
    romA[1] = mkVec(OpOr, 16'h0F00, 16'h00F0, 4'h0, 16'h0FF0, 4'h0);
    pulseStartA();
    repeat (6) @(posedge clk);
    #2;
    checkVal("E_pre_alu_x", busA.alu_x, 16'h0F00);
    readSelA(5'd4, e, t);
    checkVal("E_pre_add_total", t, 8'd1);
    rstN = 1'b0;
    #1;
    checkVal("E_rst_busy", busA.busy, 1'b0);
    checkVal("E_rst_alu_x", busA.alu_x, 16'h0);
    checkVal("E_rst_alu_op", busA.alu_op, 5'd0);
    readSelA(5'd4, e, t);
    checkVal("E_rst_add_total", t, 8'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    checkVal("E_idle_rd", busA.vec_rd, 1'b0);
    checkVal("E_idle_busy", busA.busy, 1'b0);
    pulseStartA();
    waitDoneA(60, 0, cyc, b1, r1, d1);
    checkVal("E_latency", cyc, 13);
    checkVal("E_pass", busA.pass, 1'b1);
    readSelA(5'd4, e, t);
    checkVal("E_add_total", t, 8'd1);

    // Run S: 300 mismatching OR vectors saturate the counters
    @(posedge clk);
    #1 busS.start = 1'b1;
    @(posedge clk);
    #1 busS.start = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (busS.done) begin
        cyc = i;
        break;
      end
      busS.start = (i == 100) || (i == 700);
    end
    busS.start = 1'b0;
    checkVal("S_latency", cyc, 1501);
    busS.sel_op = 5'd0;
    #1;
    checkVal("S_or_err", busS.sel_err, 8'd255);
    checkVal("S_or_total", busS.sel_total, 8'd255);
    checkVal("S_err_total", busS.err_total, 8'd255);
    checkVal("S_pass", busS.pass, 1'b0);
    checkVal("S_first_fail", busS.first_fail, 9'd0);
    checkVal("S_ff_vld", busS.first_fail_vld, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
